// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, multi-cycle redirect flushes,
// memory-wait freeze and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [4:0]           IF_Rs1_addr,
  input  logic [4:0]           IF_Rs2_addr,
  input  logic                 IF_Uses_rs1,
  input  logic                 IF_Uses_rs2,
  input  logic [4:0]           ID_Rd_addr,
  input  logic                 ID_Mem_rd_en,
  input  logic                 EX_Redirect,
  input  logic                 Mem_req,
  input  logic                 Mem_ready,
  input  logic                 Cnt_clr,
  output logic                 PC_Stall,
  output logic                 IF_Stall,
  output logic                 ID_Stall,
  output logic                 IF_Flush,
  output logic                 ID_Flush,
  output logic                 Pipe_Freeze,
  output logic [1:0]           Hazard_state,
  output logic [CNT_WIDTH-1:0] Stall_count,
  output logic [CNT_WIDTH-1:0] Flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  hz_state_t  state, state_nxt;
  hz_state_t  ret, ret_nxt;
  logic [3:0] fcnt, fcnt_nxt;

  logic lu, mw, flush_evt;
  logic pc_stall_c, if_stall_c, id_stall_c, if_flush_c, id_flush_c, freeze_c;

  assign lu = ID_Mem_rd_en && (ID_Rd_addr != 5'd0) &&
              ((IF_Uses_rs1 && (IF_Rs1_addr == ID_Rd_addr)) ||
               (IF_Uses_rs2 && (IF_Rs2_addr == ID_Rd_addr)));
  assign mw = Mem_req & ~Mem_ready;

  // Next-state and same-cycle control decode; freeze > flush > load-use
  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret;
    fcnt_nxt   = fcnt;
    flush_evt  = 1'b0;
    pc_stall_c = 1'b0;
    if_stall_c = 1'b0;
    id_stall_c = 1'b0;
    if_flush_c = 1'b0;
    id_flush_c = 1'b0;
    freeze_c   = 1'b0;
    case (state)
      RUN: begin
        if (mw) begin
          freeze_c   = 1'b1;
          pc_stall_c = 1'b1;
          if_stall_c = 1'b1;
          state_nxt  = MEM_WAIT;
          ret_nxt    = RUN;
        end else if (EX_Redirect) begin
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
          flush_evt  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FC_RELOAD;
          end
        end else if (lu) begin
          pc_stall_c = 1'b1;
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
        end
      end
      FLUSH: begin
        if (mw) begin
          // fcnt is held so the remaining flush cycles resume after the wait
          freeze_c   = 1'b1;
          pc_stall_c = 1'b1;
          if_stall_c = 1'b1;
          state_nxt  = MEM_WAIT;
          ret_nxt    = FLUSH;
        end else begin
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
          if (EX_Redirect) begin
            flush_evt = 1'b1;
            fcnt_nxt  = FC_RELOAD;
          end else if (fcnt <= 4'd1) begin
            state_nxt = RUN;
            fcnt_nxt  = 4'd0;
          end else begin
            fcnt_nxt  = fcnt - 4'd1;
          end
        end
      end
      MEM_WAIT: begin
        // Redirects are ignored here: EX is held and re-presents them later
        if (mw) begin
          freeze_c   = 1'b1;
          pc_stall_c = 1'b1;
          if_stall_c = 1'b1;
        end else begin
          state_nxt = ret;
        end
      end
      default: begin
        state_nxt = RUN;
        ret_nxt   = RUN;
        fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= RUN;
      ret   <= RUN;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_count <= '0;
      Flush_count <= '0;
    end else if (Cnt_clr) begin
      Stall_count <= '0;
      Flush_count <= '0;
    end else begin
      if (pc_stall_c) Stall_count <= sat_inc(Stall_count);
      if (flush_evt)  Flush_count <= sat_inc(Flush_count);
    end
  end

  // All controls read 0 while reset is asserted
  assign PC_Stall     = Reset_n & pc_stall_c;
  assign IF_Stall     = Reset_n & if_stall_c;
  assign ID_Stall     = Reset_n & id_stall_c;
  assign IF_Flush     = Reset_n & if_flush_c;
  assign ID_Flush     = Reset_n & id_flush_c;
  assign Pipe_Freeze  = Reset_n & freeze_c;
  assign Hazard_state = Reset_n ? state : RUN;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2, 4-bit counters so saturation is reachable).
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [4:0] IF_Rs1_addr, IF_Rs2_addr, ID_Rd_addr;
  logic       IF_Uses_rs1, IF_Uses_rs2, ID_Mem_rd_en;
  logic       EX_Redirect, Mem_req, Mem_ready, Cnt_clr;
  logic       PC_Stall, IF_Stall, ID_Stall, IF_Flush, ID_Flush, Pipe_Freeze;
  logic [1:0] Hazard_state;
  logic [3:0] Stall_count, Flush_count;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IF_Rs1_addr(IF_Rs1_addr), .IF_Rs2_addr(IF_Rs2_addr),
    .IF_Uses_rs1(IF_Uses_rs1), .IF_Uses_rs2(IF_Uses_rs2),
    .ID_Rd_addr(ID_Rd_addr), .ID_Mem_rd_en(ID_Mem_rd_en),
    .EX_Redirect(EX_Redirect), .Mem_req(Mem_req), .Mem_ready(Mem_ready),
    .Cnt_clr(Cnt_clr),
    .PC_Stall(PC_Stall), .IF_Stall(IF_Stall), .ID_Stall(ID_Stall),
    .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .Pipe_Freeze(Pipe_Freeze),
    .Hazard_state(Hazard_state), .Stall_count(Stall_count), .Flush_count(Flush_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where new inputs are applied
  task automatic next_cyc();
    @(negedge Clk);
  endtask

  // Check the combinational controls one unit after inputs settle
  task automatic chk_ctl(input string tag, input logic [1:0] st, input logic [5:0] ctl);
    #1;
    chk({tag, ".state"}, 32'(Hazard_state), 32'(st));
    chk({tag, ".ctl"}, 32'({PC_Stall, IF_Stall, ID_Stall, IF_Flush, ID_Flush, Pipe_Freeze}),
        32'(ctl));
  endtask

  task automatic idle();
    IF_Rs1_addr = 0; IF_Rs2_addr = 0; ID_Rd_addr = 0;
    IF_Uses_rs1 = 0; IF_Uses_rs2 = 0; ID_Mem_rd_en = 0;
    EX_Redirect = 0; Mem_req = 0; Mem_ready = 0; Cnt_clr = 0;
  endtask

  task automatic set_lu();
    ID_Mem_rd_en = 1; ID_Rd_addr = 5; IF_Rs2_addr = 5; IF_Uses_rs2 = 1;
  endtask

  // ctl bit order: {PC_Stall, IF_Stall, ID_Stall, IF_Flush, ID_Flush, Pipe_Freeze}
  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LU     = 6'b111000;
  localparam logic [5:0] C_FLUSH  = 6'b000110;
  localparam logic [5:0] C_FREEZE = 6'b110001;

  initial begin
    idle();
    Reset_n = 0;
    // Reset with hazard stimulus applied: all controls must stay 0
    set_lu(); EX_Redirect = 1;
    #12;
    chk_ctl("rst", 2'd0, C_NONE);
    chk("rst.scnt", 32'(Stall_count), 0);
    chk("rst.fcnt", 32'(Flush_count), 0);
    next_cyc(); idle(); Reset_n = 1;
    chk_ctl("idle", 2'd0, C_NONE);

    // Load-use on rs2: one-cycle stall, bubble clears it
    next_cyc(); set_lu();
    chk_ctl("lu_rs2", 2'd0, C_LU);
    next_cyc(); ID_Mem_rd_en = 0;
    chk_ctl("lu_clear", 2'd0, C_NONE);
    chk("lu.scnt", 32'(Stall_count), 1);
    // rd = x0 never stalls
    next_cyc(); set_lu(); ID_Rd_addr = 0; IF_Rs2_addr = 0;
    chk_ctl("lu_x0", 2'd0, C_NONE);
    // Matching rs1 but unused operand does not stall
    next_cyc(); idle(); ID_Mem_rd_en = 1; ID_Rd_addr = 7; IF_Rs1_addr = 7;
    chk_ctl("lu_unused", 2'd0, C_NONE);
    next_cyc(); IF_Uses_rs1 = 1;
    chk_ctl("lu_rs1", 2'd0, C_LU);
    next_cyc(); idle();
    chk("lu2.scnt", 32'(Stall_count), 2);

    // Single redirect: two flush cycles, state 0 -> 1 -> 0
    next_cyc(); EX_Redirect = 1;
    chk_ctl("rd0", 2'd0, C_FLUSH);
    next_cyc(); EX_Redirect = 0;
    chk_ctl("rd1", 2'd1, C_FLUSH);
    chk("rd.fcnt", 32'(Flush_count), 1);
    next_cyc();
    chk_ctl("rd_done", 2'd0, C_NONE);

    // Back-to-back redirect extends flush; load-use ignored during FLUSH
    next_cyc(); EX_Redirect = 1;
    chk_ctl("rr0", 2'd0, C_FLUSH);
    next_cyc();
    chk_ctl("rr1", 2'd1, C_FLUSH);
    chk("rr1.fcnt", 32'(Flush_count), 2);
    next_cyc(); EX_Redirect = 0; set_lu();
    chk_ctl("rr2_lu", 2'd1, C_FLUSH);
    chk("rr2.fcnt", 32'(Flush_count), 3);
    next_cyc(); idle();
    chk_ctl("rr_done", 2'd0, C_NONE);
    chk("rr.scnt", 32'(Stall_count), 2);

    // Memory wait three cycles; lu and redirect ignored while frozen
    next_cyc(); Mem_req = 1;
    chk_ctl("mw0", 2'd0, C_FREEZE);
    next_cyc(); set_lu(); EX_Redirect = 1;
    chk_ctl("mw1", 2'd2, C_FREEZE);
    next_cyc();
    chk_ctl("mw2", 2'd2, C_FREEZE);
    next_cyc(); idle(); Mem_req = 1; Mem_ready = 1;
    chk_ctl("mw_rdy", 2'd2, C_NONE);
    next_cyc(); idle();
    chk_ctl("mw_done", 2'd0, C_NONE);
    chk("mw.scnt", 32'(Stall_count), 5);
    chk("mw.fcnt", 32'(Flush_count), 3);

    // Freeze inside flush: remaining flush cycle issues after ready
    next_cyc(); EX_Redirect = 1;
    chk_ctl("ff0", 2'd0, C_FLUSH);
    next_cyc(); EX_Redirect = 0; Mem_req = 1;
    chk_ctl("ff1", 2'd1, C_FREEZE);
    next_cyc();
    chk_ctl("ff2", 2'd2, C_FREEZE);
    next_cyc(); Mem_ready = 1;
    chk_ctl("ff_rdy", 2'd2, C_NONE);
    next_cyc(); idle();
    chk_ctl("ff_resume", 2'd1, C_FLUSH);
    next_cyc();
    chk_ctl("ff_done", 2'd0, C_NONE);
    chk("ff.scnt", 32'(Stall_count), 7);
    chk("ff.fcnt", 32'(Flush_count), 4);

    // Mem_req dropping without ready also leaves MEM_WAIT
    next_cyc(); Mem_req = 1;
    chk_ctl("drop0", 2'd0, C_FREEZE);
    next_cyc(); Mem_req = 0;
    chk_ctl("drop1", 2'd2, C_NONE);
    next_cyc();
    chk_ctl("drop_done", 2'd0, C_NONE);
    chk("drop.scnt", 32'(Stall_count), 8);

    // Ten more stall cycles: 8 + 10 saturates at 15
    for (int i = 0; i < 10; i++) begin
      next_cyc(); set_lu();
    end
    next_cyc(); idle();
    #1 chk("sat.scnt", 32'(Stall_count), 15);
    // Clear wins over a simultaneous increment
    next_cyc(); set_lu(); Cnt_clr = 1;
    chk_ctl("clr_lu", 2'd0, C_LU);
    next_cyc(); idle();
    #1 chk("clr.scnt", 32'(Stall_count), 0);
    chk("clr.fcnt", 32'(Flush_count), 0);

    // Reset while in MEM_WAIT
    next_cyc(); Mem_req = 1;
    next_cyc();
    chk_ctl("rw_wait", 2'd2, C_FREEZE);
    chk("rw.scnt", 32'(Stall_count), 1);
    #2 Reset_n = 0;
    #1 chk("rw_rst.ctl", 32'({PC_Stall, IF_Stall, ID_Stall, IF_Flush, ID_Flush, Pipe_Freeze}), 0);
    chk("rw_rst.state", 32'(Hazard_state), 0);
    chk("rw_rst.scnt", 32'(Stall_count), 0);
    next_cyc(); Reset_n = 1; Mem_req = 0;
    chk_ctl("rw_rel", 2'd0, C_NONE);
    chk("rw_rel.scnt", 32'(Stall_count), 0);
    chk("rw_rel.fcnt", 32'(Flush_count), 0);
    // ret must have been reset: a ready cycle after release keeps RUN
    next_cyc(); EX_Redirect = 1;
    chk_ctl("rw_rd", 2'd0, C_FLUSH);
    next_cyc(); idle();
    chk_ctl("rw_rd1", 2'd1, C_FLUSH);
    next_cyc();
    chk_ctl("rw_rd_done", 2'd0, C_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the RV32I core. It drives the stall, flush and freeze controls of the IF, ID and EX pipeline registers, including the ID stage's ID_Stall and ID_Flush inputs. It detects load-use hazards, sequences multi-cycle flushes after branch/jump redirects from EX, and freezes the pipe while a data-memory access waits for ready. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles IF_Flush/ID_Flush are asserted per redirect (legal 1..15)
CNT_WIDTH, 32, width of the performance counters

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
IF_Rs1_addr  in  5  rs1 field of the instruction currently being decoded
IF_Rs2_addr  in  5  rs2 field of the instruction currently being decoded
IF_Uses_rs1  in  1  the decoded instruction reads rs1
IF_Uses_rs2  in  1  the decoded instruction reads rs2
ID_Rd_addr  in  5  rd of the instruction in EX (ID/EX register)
ID_Mem_rd_en  in  1  the instruction in EX is a load
EX_Redirect  in  1  branch taken or jump resolved in EX this cycle
Mem_req  in  1  data memory access active in MEM
Mem_ready  in  1  data memory completes the access this cycle
Cnt_clr  in  1  synchronous clear of both counters
PC_Stall  out  1  hold PC
IF_Stall  out  1  hold the IF/ID register
ID_Stall  out  1  insert a bubble into ID/EX
IF_Flush  out  1  clear the IF/ID register
ID_Flush  out  1  clear the ID/EX register
Pipe_Freeze  out  1  hold every pipeline register including EX/MEM and MEM/WB
Hazard_state  out  2  FSM state: 0 RUN, 1 FLUSH, 2 MEM_WAIT
Stall_count  out  CNT_WIDTH  cycles with PC_Stall=1, saturating
Flush_count  out  CNT_WIDTH  redirect events, saturating

Behaviour:
- Load-use term, combinational: lu = ID_Mem_rd_en & (ID_Rd_addr != 0) & ((IF_Uses_rs1 & IF_Rs1_addr == ID_Rd_addr) | (IF_Uses_rs2 & IF_Rs2_addr == ID_Rd_addr)).
- Freeze term: mw = Mem_req & ~Mem_ready.
- Outputs are combinational from the registered state plus current inputs, same-cycle, no added latency.
- While Reset_n=0, every output is forced to 0.
- Priority: freeze > flush > load-use.
- RUN state:
  - If mw: Pipe_Freeze=PC_Stall=IF_Stall=1, all others 0. Next state MEM_WAIT; save ret=RUN.
  - Else if EX_Redirect: IF_Flush=ID_Flush=1, Flush_count+1. If FLUSH_CYCLES>1, next state FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else if lu: PC_Stall=IF_Stall=ID_Stall=1 for that cycle only. The bubble clears ID_Mem_rd_en, so the hazard self-clears next cycle.
  - Else: all controls 0.
- FLUSH state:
  - Normally IF_Flush=ID_Flush=1 and fcnt decrements. When fcnt reaches 1 and no new event occurs, go to RUN.
  - A new EX_Redirect reloads fcnt=FLUSH_CYCLES-1 and increments Flush_count.
  - lu is ignored; flush dominates.
  - If mw: freeze as in RUN, flush outputs 0 that cycle, fcnt held, save ret=FLUSH.
- MEM_WAIT state:
  - Pipe_Freeze=PC_Stall=IF_Stall=1 while Mem_ready=0.
  - In the cycle Mem_ready=1, all freeze outputs are 0 and the next state is ret, with fcnt preserved.
  - EX_Redirect is ignored while frozen, because EX is held and its redirect repeats after unfreeze.
  - If Mem_req drops without Mem_ready, also return to ret.
- Counters:
  - Stall_count increments in every cycle with PC_Stall=1.
  - Flush_count increments once per accepted redirect.
  - Both saturate at all-ones.
  - Cnt_clr has priority over increment, and the result is 0 next cycle.
- Reset, including mid-flush or mid-wait: state=RUN, fcnt=0, ret=RUN, both counters 0, asynchronously.
- An illegal Hazard_state encoding (3) returns to RUN next cycle.

Test Plan:
- Load-use: ID_Mem_rd_en=1, ID_Rd_addr=5, IF_Rs2_addr=5, IF_Uses_rs2=1 -> PC_Stall/IF_Stall/ID_Stall=1 for exactly 1 cycle. Stall_count=1. With ID_Rd_addr=0 the same stimulus gives no stall.
- Redirect, FLUSH_CYCLES=2: EX_Redirect pulse -> IF_Flush=ID_Flush=1 for 2 cycles, Hazard_state 0->1->0, Flush_count=1. A second redirect in the FLUSH cycle -> flush extends 2 more cycles, Flush_count=2.
- Memory wait: Mem_req=1, Mem_ready=0 for 3 cycles then 1 -> Pipe_Freeze=1 for 3 cycles, 0 on the ready cycle. Stall_count=3. Simultaneous lu and EX_Redirect are ignored during the freeze.
- Freeze inside flush: redirect, then mw in the next cycle for 2 cycles -> flush suspended, fcnt held, and the remaining flush cycle issues after ready.
- Counters: preload Stall_count near saturation (force or long stall), continue stalling -> holds at 2^CNT_WIDTH-1. Cnt_clr -> 0 next cycle.
- Reset mid-MEM_WAIT: drop Reset_n -> all outputs 0 immediately. After release: Hazard_state=0 and counters 0.
